// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback vs buffered multicycle
// results, with a one-cycle drain stall when a buffered result starves.
module rf_wport_arb #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_v_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  input  logic        mc_v_i,
  input  logic [4:0]  mc_rd_i,
  input  logic [31:0] mc_data_i,
  output logic        mc_ready_o,
  output logic        rf_w_v_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_data_o,
  output logic        stall_v_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [SW-1:0] starve_inc;

  logic [4:0]  rd_mem_q   [FIFO_DEPTH];
  logic [31:0] data_mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, wb_win;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign mc_ready_o = !full;
  assign push = mc_v_i && !full;

  assign wb_win = wb_v_i && (state_q != DRAIN);
  assign pop    = !wb_win && !empty;

  assign win_rd   = wb_win ? wb_rd_i : rd_mem_q[rptr_q];
  assign win_data = wb_win ? wb_data_i : data_mem_q[rptr_q];

  // x0 writes still consume their slot; only the enable is suppressed
  assign rf_w_v_o  = rst_ni && (wb_win || pop) && (win_rd != 5'd0);
  assign rf_rd_o   = win_rd;
  assign rf_data_o = win_data;
  assign stall_v_o = (state_q == DRAIN);

  assign starve_inc = (starve_q == SW'(STARVE_LIMIT)) ? starve_q
                                                     : starve_q + SW'(1);

  always_comb begin
    wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d    = cnt_q;
    starve_d = '0;
    state_d  = state_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (!empty && !pop) starve_d = starve_inc;
    unique case (state_q)
      IDLE: if (push) state_d = WAIT;
      WAIT: begin
        if (cnt_d == '0)
          state_d = IDLE;
        else if (!pop && starve_inc == SW'(STARVE_LIMIT))
          state_d = DRAIN;
      end
      DRAIN: state_d = (cnt_d != '0) ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= mc_rd_i;
      data_mem_q[wptr_q] <= mc_data_i;
    end
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: directed scenarios plus random traffic
// against a queue-based reference of the arbitration rules.
module tb_rf_wport_arb;

  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic        clk_i = 0;
  logic        rst_ni = 0;
  logic        wb_v_i = 0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        mc_v_i = 0;
  logic [4:0]  mc_rd_i = '0;
  logic [31:0] mc_data_i = '0;
  logic        mc_ready_o, rf_w_v_o, stall_v_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;

  rf_wport_arb #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .mc_v_i(mc_v_i), .mc_rd_i(mc_rd_i), .mc_data_i(mc_data_i),
    .mc_ready_o(mc_ready_o), .rf_w_v_o(rf_w_v_o),
    .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o), .stall_v_o(stall_v_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // reference: pending multicycle results in order, plus lost-cycle count
  logic [36:0] mq[$];
  int  m_lost = 0;
  bit  m_stall = 0;

  logic o_wv, o_ready, o_stall;
  logic [4:0] o_rd;
  logic [31:0] o_data;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_lost = 0;
    m_stall = 0;
  endtask

  task automatic step(input logic wv, input logic [4:0] wrd,
                      input logic [31:0] wd, input logic mv,
                      input logic [4:0] mrd, input logic [31:0] md);
    bit pipe, popq, push, had;
    logic [4:0] erd;
    logic [31:0] ed;
    @(negedge clk_i);
    wb_v_i = wv; wb_rd_i = wrd; wb_data_i = wd;
    mc_v_i = mv; mc_rd_i = mrd; mc_data_i = md;
    #1;
    o_wv = rf_w_v_o; o_ready = mc_ready_o; o_stall = stall_v_o;
    o_rd = rf_rd_o; o_data = rf_data_o;
    had  = mq.size() > 0;
    pipe = wv && !m_stall;
    popq = !pipe && had;
    push = mv && (mq.size() < DEPTH);
    erd = pipe ? wrd : (popq ? mq[0][36:32] : 5'd0);
    ed  = pipe ? wd  : (popq ? mq[0][31:0] : 32'd0);
    chk("stall", {31'd0, o_stall}, {31'd0, m_stall});
    chk("ready", {31'd0, o_ready}, {31'd0, push || !mv ? mq.size() < DEPTH : 1'b0});
    chk("wen", {31'd0, o_wv}, {31'd0, (pipe || popq) && erd != 0});
    if ((pipe || popq) && erd != 0) begin
      chk("rd", {27'd0, o_rd}, {27'd0, erd});
      chk("data", o_data, ed);
    end
    if (popq) void'(mq.pop_front());
    if (m_stall) begin
      m_stall = 0;
      m_lost = 0;
    end else if (popq || !had) begin
      m_lost = 0;
    end else begin
      m_lost = (m_lost + 1 > LIMIT) ? LIMIT : m_lost + 1;
      if (m_lost >= LIMIT) m_stall = 1;
    end
    if (push) mq.push_back({mrd, md});
    @(posedge clk_i);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_stall", {31'd0, stall_v_o}, 32'd0);
    chk("rst_wen", {31'd0, rf_w_v_o}, 32'd0);
    chk("rst_ready", {31'd0, mc_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_ni = 1;
    model_reset();

    // idle pipeline: push then written next cycle
    step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0);
    chk("idle_wen", {31'd0, o_wv}, 32'd1);
    chk("idle_rd", {27'd0, o_rd}, 32'd5);
    chk("idle_data", o_data, 32'hDEADBEEF);
    idle();
    chk("idle_ready", {31'd0, o_ready}, 32'd1);

    // starvation: pipeline busy, drain on 4th cycle after push
    step(1, 5'd3, 32'h100, 1, 5'd7, 32'h77);
    step(1, 5'd3, 32'h101, 0, 0, 0);
    step(1, 5'd3, 32'h102, 0, 0, 0);
    step(1, 5'd3, 32'h103, 0, 0, 0);
    chk("starve_nostall", {31'd0, o_stall}, 32'd0);
    step(1, 5'd3, 32'h104, 0, 0, 0);
    chk("starve_stall", {31'd0, o_stall}, 32'd1);
    chk("starve_rd", {27'd0, o_rd}, 32'd7);
    step(1, 5'd3, 32'h104, 0, 0, 0);
    chk("starve_resume", {27'd0, o_rd}, 32'd3);
    chk("starve_resume_st", {31'd0, o_stall}, 32'd0);
    idle();

    // full: two pushes under busy pipeline, third refused until pop
    step(1, 5'd4, 32'h1, 1, 5'd8, 32'hA);
    step(1, 5'd4, 32'h2, 1, 5'd9, 32'hB);
    step(1, 5'd4, 32'h3, 1, 5'd10, 32'hC);
    chk("full_ready", {31'd0, o_ready}, 32'd0);
    step(1, 5'd4, 32'h4, 1, 5'd10, 32'hC);
    step(1, 5'd4, 32'h5, 1, 5'd10, 32'hC);
    chk("full_drain_rd", {27'd0, o_rd}, 32'd8);
    repeat (8) step(1, 5'd4, 32'h6, 0, 0, 0);
    repeat (4) idle();

    // x0 handling
    step(1, 5'd0, 32'h55, 0, 0, 0);
    chk("x0_wb", {31'd0, o_wv}, 32'd0);
    step(0, 0, 0, 1, 5'd0, 32'h66);
    step(0, 0, 0, 0, 0, 0);
    chk("x0_mc", {31'd0, o_wv}, 32'd0);
    chk("x0_ready", {31'd0, o_ready}, 32'd1);

    // reset while draining
    step(1, 5'd2, 32'h9, 1, 5'd11, 32'hEE);
    repeat (3) step(1, 5'd2, 32'h9, 0, 0, 0);
    @(negedge clk_i);
    chk("pre_rst_stall", {31'd0, stall_v_o}, 32'd1);
    rst_ni = 0;
    #1;
    chk("rst_drain_stall", {31'd0, stall_v_o}, 32'd0);
    chk("rst_drain_wen", {31'd0, rf_w_v_o}, 32'd0);
    chk("rst_drain_ready", {31'd0, mc_ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1;
    wb_v_i = 0;
    model_reset();
    repeat (3) idle();

    // concurrent push/pop, one held entry, across pointer wrap
    step(0, 0, 0, 1, 5'd20, 32'h200);
    for (int i = 1; i <= 8; i++)
      step(0, 0, 0, 1, 5'(20 + i), 32'h200 + i);
    chk("wrap_last_rd", {27'd0, o_rd}, 32'd27);
    idle();
    chk("wrap_tail_rd", {27'd0, o_rd}, 32'd28);

    // random traffic against the reference
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), 5'($urandom), $urandom,
           ($urandom_range(0, 9) < 4), 5'($urandom), $urandom);
    repeat (8) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
